// File: rtl/bw_seq_multiplier_if.sv
// Handshake, observation and result bundle for the sequential
// Baugh-Wooley multiplier. The slave modport is the multiplier side and
// the master modport is the producer/consumer side.
interface bw_seq_multiplier_if #(
  parameter int WIDTH = 16
);
  localparam int IDX_W = $clog2(WIDTH);

  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_a;
  logic [WIDTH-1:0]   in_b;
  logic               in_signed;

  logic               row_valid;
  logic [WIDTH-1:0]   row_data;
  logic [IDX_W-1:0]   row_idx;

  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] out_product;

  modport master (
    output in_valid, in_a, in_b, in_signed, out_ready,
    input  in_ready, row_valid, row_data, row_idx, out_valid, out_product
  );

  modport slave (
    input  in_valid, in_a, in_b, in_signed, out_ready,
    output in_ready, row_valid, row_data, row_idx, out_valid, out_product
  );
endinterface

// File: rtl/bw_seq_multiplier.sv
// Sequential Baugh-Wooley multiplier. One WIDTH-bit partial-product row
// is generated and accumulated per clock; a single correction cycle adds
// the signed-mode constant, then the 2*WIDTH-bit product is offered on a
// valid/ready handshake. Every row is also visible on the observation
// port while it is being accumulated.
module bw_seq_multiplier #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  bw_seq_multiplier_if.slave bus
);

  localparam int IDX_W = $clog2(WIDTH);
  localparam int ACC_W = 2 * WIDTH;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);
  localparam logic [ACC_W-1:0] ACC_ONE  = ACC_W'(1);
  // Folds the constant terms of all inverted Baugh-Wooley bits into one add.
  localparam logic [ACC_W-1:0] CORR_K   = (ACC_ONE << WIDTH) | (ACC_ONE << (ACC_W - 1));
  localparam logic [WIDTH-1:0] ROW_ONE  = WIDTH'(1);
  localparam logic [WIDTH-1:0] MSB_MASK = ROW_ONE << (WIDTH - 1);
  localparam logic [WIDTH-1:0] LOW_MASK = ~MSB_MASK;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ROW  = 2'd1,
    CORR = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_nextState;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_signed;
  logic [ACC_W-1:0] r_acc;
  logic [IDX_W-1:0] r_idx;

  logic             w_bBit;
  logic             w_lastRow;
  logic [WIDTH-1:0] w_andRow;
  logic [WIDTH-1:0] w_rowData;
  logic [ACC_W-1:0] w_rowExt;
  logic [ACC_W-1:0] w_rowShift;

  logic             w_inReady;
  logic             w_rowValid;
  logic             w_outValid;
  logic             w_accept;
  logic             w_release;

  // State register; reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state and handshake outputs. ROW stays put until the last row
  // index is reached; DONE waits for the consumer without a timeout.
  always_comb begin
    w_nextState = r_state;
    w_inReady   = 1'b0;
    w_rowValid  = 1'b0;
    w_outValid  = 1'b0;
    w_accept    = 1'b0;
    w_release   = 1'b0;
    case (r_state)
      IDLE: begin
        w_inReady = 1'b1;
        if (bus.in_valid) begin
          w_accept    = 1'b1;
          w_nextState = ROW;
        end
      end
      ROW: begin
        w_rowValid = 1'b1;
        if (w_lastRow) begin
          w_nextState = CORR;
        end
      end
      CORR: begin
        w_nextState = DONE;
      end
      DONE: begin
        w_outValid = 1'b1;
        if (bus.out_ready) begin
          w_release   = 1'b1;
          w_nextState = IDLE;
        end
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // Partial-product row for the current index. Signed mode inverts the
  // MSB of ordinary rows and all but the MSB of the final row; unsigned
  // mode is a plain AND array. Because the row index stops at the last
  // row and operands only change on accept, the row output naturally
  // holds its last value outside ROW.
  always_comb begin
    w_bBit    = r_b[r_idx];
    w_lastRow = (r_idx == LAST_IDX);
    w_andRow  = r_a & {WIDTH{w_bBit}};
    w_rowData = w_andRow;
    if (r_signed) begin
      if (w_lastRow) begin
        w_rowData = w_andRow ^ LOW_MASK;
      end else begin
        w_rowData = w_andRow ^ MSB_MASK;
      end
    end
    w_rowExt   = {{WIDTH{1'b0}}, w_rowData};
    w_rowShift = w_rowExt << r_idx;
  end

  // Datapath: operand capture on accept, row accumulation with a wrapping
  // 2*WIDTH-bit adder, and the signed correction add in CORR.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a      <= '0;
      r_b      <= '0;
      r_signed <= 1'b0;
      r_acc    <= '0;
      r_idx    <= '0;
    end else begin
      if (w_accept) begin
        r_a      <= bus.in_a;
        r_b      <= bus.in_b;
        r_signed <= bus.in_signed;
        r_acc    <= '0;
        r_idx    <= '0;
      end else if (w_rowValid) begin
        r_acc <= r_acc + w_rowShift;
        if (!w_lastRow) begin
          r_idx <= r_idx + IDX_W'(1);
        end
      end else if ((r_state == CORR) && r_signed) begin
        r_acc <= r_acc + CORR_K;
      end
    end
  end

  assign bus.in_ready    = w_inReady;
  assign bus.row_valid   = w_rowValid;
  assign bus.row_data    = w_rowData;
  assign bus.row_idx     = r_idx;
  assign bus.out_valid   = w_outValid;
  assign bus.out_product = r_acc;

  // w_release is the DONE handshake; kept explicit for readability of
  // the FSM even though the state register already consumes it.
  logic w_unusedRelease;
  assign w_unusedRelease = w_release;

endmodule

// File: tb/tb_bw_seq_multiplier.sv
// Self-checking bench for bw_seq_multiplier: a 16-bit instance driven
// from a vector table plus hand-written corner sequences, and a 4-bit
// instance run exhaustively back-to-back against a reference model.
module tb_bw_seq_multiplier;

  localparam int W  = 16;
  localparam int WS = 4;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  bw_seq_multiplier_if #(.WIDTH(W))  bus16 ();
  bw_seq_multiplier_if #(.WIDTH(WS)) bus4 ();

  bw_seq_multiplier #(.WIDTH(W))  dut16 (.clk(clk), .rst(rst), .bus(bus16.slave));
  bw_seq_multiplier #(.WIDTH(WS)) dut4  (.clk(clk), .rst(rst), .bus(bus4.slave));

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        s;
    logic [31:0] prod;
  } vec_t;

  vec_t        vecs[10];
  logic [31:0] sb16[$];
  logic [7:0]  sb4[$];
  logic [15:0] lastRows[16];
  int          errors = 0;
  int          checks = 0;

  // Compare one observed value against the bench's expectation.
  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  function automatic logic [31:0] ref16(input logic [15:0] a, input logic [15:0] b,
                                        input logic s);
    logic [31:0] ea, eb;
    ea = s ? {{16{a[15]}}, a} : {16'h0, a};
    eb = s ? {{16{b[15]}}, b} : {16'h0, b};
    return ea * eb;
  endfunction

  function automatic logic [7:0] ref4(input logic [3:0] a, input logic [3:0] b,
                                      input logic s);
    logic [7:0] ea, eb;
    ea = s ? {{4{a[3]}}, a} : {4'h0, a};
    eb = s ? {{4{b[3]}}, b} : {4'h0, b};
    return ea * eb;
  endfunction

  // Run one 16-bit operation: accept, watch the rows, check latency,
  // optionally stall the consumer and/or poke in_valid while busy, then
  // pop the scoreboard against the delivered product.
  task automatic applyStimulus16(input logic [15:0] a, input logic [15:0] b,
                                 input logic s, input logic [31:0] expProd,
                                 input int holdCycles, input bit pulseBusy,
                                 input string name);
    int   edges;
    int   rows;
    bit   orderOk;
    logic [31:0] exp;
    @(negedge clk);
    edges = 0;
    while (!bus16.in_ready && edges < 100) begin
      @(negedge clk);
      edges++;
    end
    checkOutput({name, " in_ready"}, bus16.in_ready, 1);
    bus16.out_ready = (holdCycles == 0);
    bus16.in_a      = a;
    bus16.in_b      = b;
    bus16.in_signed = s;
    bus16.in_valid  = 1'b1;
    sb16.push_back(expProd);
    @(posedge clk);
    @(negedge clk);
    bus16.in_valid  = 1'b0;
    bus16.in_a      = ~a;
    bus16.in_b      = ~b;
    bus16.in_signed = ~s;
    edges   = 0;
    rows    = 0;
    orderOk = 1'b1;
    while (!bus16.out_valid && edges < 100) begin
      if (bus16.row_valid) begin
        if (rows < 16) begin
          if (bus16.row_idx != rows[3:0]) orderOk = 1'b0;
          lastRows[rows[3:0]] = bus16.row_data;
        end
        rows++;
      end
      if (pulseBusy && edges == 3) begin
        bus16.in_valid = 1'b1;
        bus16.in_a     = 16'h0BAD;
        bus16.in_b     = 16'h0F00;
      end else begin
        bus16.in_valid = 1'b0;
      end
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    bus16.in_valid = 1'b0;
    checkOutput({name, " latency"}, edges, W + 1);
    checkOutput({name, " rowCount"}, rows, W);
    checkOutput({name, " rowOrder"}, orderOk, 1);
    for (int k = 0; k < holdCycles; k++) begin
      @(posedge clk);
      @(negedge clk);
      checkOutput({name, " holdValid"}, bus16.out_valid, 1);
      checkOutput({name, " holdProduct"}, bus16.out_product, expProd);
      checkOutput({name, " holdInReady"}, bus16.in_ready, 0);
    end
    bus16.out_ready = 1'b1;
    if (sb16.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s scoreboard: got empty queue, expected one entry", name);
    end else begin
      exp = sb16.pop_front();
      checkOutput({name, " product"}, bus16.out_product, exp);
    end
    @(posedge clk);
    @(negedge clk);
    checkOutput({name, " validDrop"}, bus16.out_valid, 0);
  endtask

  // Watchdog so a stuck design still ends the run.
  initial begin
    #800000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int   waitCnt;
    int   got;
    int   seen;
    logic [7:0] exp4;

    vecs[0] = '{16'hFFFF, 16'hFFFF, 1'b1, 32'h00000001};
    vecs[1] = '{16'h8000, 16'h8000, 1'b1, 32'h40000000};
    vecs[2] = '{16'h7FFF, 16'h8000, 1'b1, 32'hC0008000};
    vecs[3] = '{16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001};
    vecs[4] = '{16'h0001, 16'h8000, 1'b1, 32'hFFFF8000};
    vecs[5] = '{16'h0000, 16'h1234, 1'b0, 32'h00000000};
    vecs[6] = '{16'h0003, 16'hFFFE, 1'b1, 32'hFFFFFFFA};
    vecs[7] = '{16'h8000, 16'h0002, 1'b0, 32'h00010000};
    vecs[8] = '{16'h1234, 16'h5678, 1'b1, 32'h06260060};
    vecs[9] = '{16'h0001, 16'h8000, 1'b0, 32'h00008000};

    bus16.in_valid = 1'b0; bus16.in_a = '0; bus16.in_b = '0;
    bus16.in_signed = 1'b0; bus16.out_ready = 1'b1;
    bus4.in_valid = 1'b0; bus4.in_a = '0; bus4.in_b = '0;
    bus4.in_signed = 1'b0; bus4.out_ready = 1'b1;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checkOutput("reset in_ready", bus16.in_ready, 1);
    checkOutput("reset row_valid", bus16.row_valid, 0);
    checkOutput("reset row_data", bus16.row_data, 0);
    checkOutput("reset row_idx", bus16.row_idx, 0);
    checkOutput("reset out_valid", bus16.out_valid, 0);
    checkOutput("reset out_product", bus16.out_product, 0);
    checkOutput("reset w4 in_ready", bus4.in_ready, 1);

    for (int v = 0; v < 10; v++) begin
      applyStimulus16(vecs[v].a, vecs[v].b, vecs[v].s, vecs[v].prod, 0, 1'b0,
                      $sformatf("vec%0d", v));
    end

    applyStimulus16(16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001, 0, 1'b0, "unsRows");
    for (int r = 0; r < 16; r++) begin
      checkOutput($sformatf("unsRows row%0d", r), lastRows[r], 16'hFFFF);
    end

    applyStimulus16(16'h0001, 16'h8000, 1'b1, 32'hFFFF8000, 0, 1'b0, "sgnRows");
    for (int r = 0; r < 15; r++) begin
      checkOutput($sformatf("sgnRows row%0d", r), lastRows[r], 16'h8000);
    end
    checkOutput("sgnRows row15", lastRows[15], 16'h7FFE);

    applyStimulus16(16'h1234, 16'h5678, 1'b1, ref16(16'h1234, 16'h5678, 1'b1), 10, 1'b1,
                    "holdBusy");
    seen = 0;
    repeat (25) begin
      @(negedge clk);
      if (bus16.out_valid) seen++;
    end
    checkOutput("holdBusy noExtraOutput", seen, 0);

    // Reset in the middle of row 5 discards the operation.
    @(negedge clk);
    bus16.in_a = 16'h4321; bus16.in_b = 16'h1111; bus16.in_signed = 1'b1;
    bus16.in_valid = 1'b1;
    sb16.push_back(ref16(16'h4321, 16'h1111, 1'b1));
    @(posedge clk);
    @(negedge clk);
    bus16.in_valid = 1'b0;
    waitCnt = 0;
    while (!(bus16.row_valid && bus16.row_idx == 4'd5) && waitCnt < 50) begin
      @(negedge clk);
      waitCnt++;
    end
    checkOutput("midReset reachedRow5", bus16.row_idx, 5);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    void'(sb16.pop_back());
    checkOutput("midReset in_ready", bus16.in_ready, 1);
    checkOutput("midReset out_valid", bus16.out_valid, 0);
    checkOutput("midReset row_valid", bus16.row_valid, 0);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus16.out_valid) seen++;
    end
    checkOutput("midReset noProduct", seen, 0);

    // Exhaustive 4-bit run with in_valid held high and random backpressure.
    got = 0;
    @(negedge clk);
    fork
      begin
        for (int k = 0; k < 512; k++) begin
          bus4.in_a      = k[3:0];
          bus4.in_b      = k[7:4];
          bus4.in_signed = k[8];
          bus4.in_valid  = 1'b1;
          waitCnt = 0;
          while (!bus4.in_ready && waitCnt < 60) begin
            @(negedge clk);
            waitCnt++;
          end
          if (!bus4.in_ready) begin
            checkOutput("w4 acceptTimeout", bus4.in_ready, 1);
            break;
          end
          sb4.push_back(ref4(k[3:0], k[7:4], k[8]));
          @(posedge clk);
          @(negedge clk);
        end
        bus4.in_valid = 1'b0;
      end
      begin
        int cyc;
        cyc = 0;
        while (got < 512 && cyc < 20000) begin
          @(negedge clk);
          cyc++;
          bus4.out_ready = ($urandom_range(0, 3) != 0);
          if (bus4.out_valid && bus4.out_ready) begin
            got++;
            if (sb4.size() == 0) begin
              checks++;
              errors++;
              $display("[TB] FAIL w4 scoreboard: got unexpected product 0x%0h, expected none",
                       bus4.out_product);
            end else begin
              exp4 = sb4.pop_front();
              checkOutput("w4 product", bus4.out_product, exp4);
            end
          end
        end
      end
    join
    bus4.out_ready = 1'b1;
    repeat (20) @(negedge clk);
    checkOutput("w4 productCount", got, 512);
    checkOutput("w4 leftover", sb4.size(), 0);
    checkOutput("w4 idleOut", bus4.out_valid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bw_seq_multiplier.md
Name: bw_seq_multiplier

Overview:
- Parametrised sequential Baugh-Wooley multiplier; successor to the fixed 16-bit single-row partial-product generator.
- Generates one WIDTH-bit partial-product row per clock, with the Baugh-Wooley inversion rule selected per row index and mode (signed/unsigned).
- Accumulates the shifted rows, applies the signed correction constant, and returns the 2*WIDTH-bit product over a valid/ready handshake.
- Rows are also exported on an observation port, so partial-product generation stays verifiable row by row inside the multiplier datapath.

Parameters:
- WIDTH, 16, operand width in bits; legal range 2..64.
- IDX_W, $clog2(WIDTH), width of row_idx; derived, never overridden.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand request.
- in_ready  output  1  high only in IDLE.
- in_a  input  WIDTH  multiplicand A.
- in_b  input  WIDTH  multiplier B.
- in_signed  input  1  1 = two's-complement Baugh-Wooley; 0 = unsigned AND array.
- row_valid  output  1  current row_data/row_idx valid; no backpressure.
- row_data  output  WIDTH  partial-product row for index row_idx.
- row_idx  output  IDX_W  row index i (0..WIDTH-1).
- out_valid  output  1  product available.
- out_ready  input  1  consumer accepts product.
- out_product  output  2*WIDTH  product modulo 2^(2*WIDTH).

Behaviour:
- Reset
  - rst is sampled on clk edge.
  - State goes to IDLE; accumulator, captured operands, mode and row counter all clear.
  - Outputs after reset: in_ready=1, row_valid=0, row_data=0, row_idx=0, out_valid=0, out_product=0.
  - Reset mid-operation aborts immediately; the result is discarded and no out_valid follows.
- FSM states: IDLE, ROW, CORR, DONE.
- IDLE
  - in_ready=1.
  - On an edge with in_valid=1, capture A, B and mode, clear the accumulator, set i=0, go to ROW.
- ROW
  - in_ready=0 and row_valid=1.
  - row_idx=i; row_data is combinational from the captured A, B and mode.
  - On each edge, acc += zero-extend(row_data) << i and i increments.
  - After row WIDTH-1 is accumulated, go to CORR.
  - Exactly WIDTH row cycles, indices in order 0..WIDTH-1, no gaps.
- Row rule, signed mode, row i < WIDTH-1:
  - bit j < WIDTH-1 = a_j & b_i.
  - bit WIDTH-1 = ~(a_{WIDTH-1} & b_i).
- Row rule, signed mode, row WIDTH-1:
  - bit j < WIDTH-1 = ~(a_j & b_{WIDTH-1}).
  - bit WIDTH-1 = a_{WIDTH-1} & b_{WIDTH-1}.
- Row rule, unsigned mode: every bit = a_j & b_i; no inversions.
- CORR (one cycle)
  - acc += 2^WIDTH + 2^(2*WIDTH-1) if signed, else += 0.
  - Then go to DONE.
- DONE
  - out_valid=1; out_product=acc, held stable until handshake.
  - Edge with out_valid & out_ready goes to IDLE; out_valid drops the next cycle.
  - out_ready low holds DONE indefinitely, with no change to out_product.
- Latency and throughput
  - out_valid rises WIDTH+1 edges after the accepting edge.
  - Minimum initiation interval WIDTH+3 cycles (accept, WIDTH rows, CORR, DONE handshake cycle).
- Arithmetic: accumulator is 2*WIDTH bits; all adds wrap modulo 2^(2*WIDTH); carry-out is discarded.
- Busy handling: in_valid while not in IDLE is ignored; operands are not captured or queued.
- Outside ROW: row_valid=0; row_data and row_idx hold their last values, and after reset they are 0.
- in_a, in_b and in_signed are sampled only on the accept edge; later changes have no effect.

Test Plan:
- WIDTH=16, signed, A=0xFFFF, B=0xFFFF, out_ready=1 → out_product=0x00000001; out_valid rises exactly 17 edges after accept.
- WIDTH=16, signed, A=0x8000, B=0x8000 → 0x40000000. Also A=0x7FFF, B=0x8000 → 0xC0008000.
- WIDTH=16, unsigned, A=0xFFFF, B=0xFFFF → 0xFFFE0001; no inversion in any row (row_data=0xFFFF for every i).
- WIDTH=16, signed, A=0x0001, B=0x8000 → rows 0..14 each 0x8000, row 15 = 0x7FFE, product 0xFFFF8000.
- Handshake case: out_ready=0 for 10 cycles in DONE → out_valid/out_product stable and in_ready=0. Pulsing in_valid with new operands during ROW is ignored. Asserting rst at row 5 → next cycle in_ready=1, out_valid=0, no product emitted.
- WIDTH=4: exhaustive 256×2 operand/mode pairs, back-to-back with in_valid held high → every product matches a reference model; no accept lost or duplicated.
